// File: rtl/ssd_entry_ctrl.sv
// ssd_entry_ctrl - keypad-entry display controller for a multiplexed SSD.
//
// Key codes arrive as single-cycle strobes and are shifted into a digit
// buffer with the newest digit on the right (digit 0). A free-running scan
// counter walks a one-hot digit select across NUM_DIGITS positions. It
// drives the hex-decoded value of the selected digit on the shared segment
// bus. Digits that have not been entered are blanked.
//
// Strobe semantics: key_valid, backspace and clear have no ready or
// back-pressure. Each one acts at the clock edge where it is sampled high.
// When several are high together, only the highest priority one acts
// (clear > backspace > key_valid).
//
// Optional build macro: FULL_BLINK_EN. When it is defined, a full buffer
// blinks the whole display at BLINK_DIV cycles per half-period.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   key_valid  in   strobe: key_code is valid
//   key_code   in   4-bit hex key value
//   backspace  in   strobe: remove newest digit
//   clear      in   strobe: empty the buffer
//   seg        out  segments {g,f,e,d,c,b,a}, active-high, registered
//   digit_sel  out  one-hot digit enable, registered, bit 0 = rightmost
//   count      out  number of digits currently entered
//   full       out  count == NUM_DIGITS
//   key_drop   out  one-cycle pulse: key rejected (lock mode, buffer full)
module ssd_entry_ctrl #(
    parameter int NUM_DIGITS     = 2,
    parameter int SCAN_DIV       = 62_500,
    parameter int LOCK_WHEN_FULL = 0,
    parameter int BLINK_DIV      = 31_250_000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              key_valid,
    input  logic [3:0]                        key_code,
    input  logic                              backspace,
    input  logic                              clear,
    output logic [6:0]                        seg,
    output logic [NUM_DIGITS-1:0]             digit_sel,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   count,
    output logic                              full,
    output logic                              key_drop
);

    localparam int CW = $clog2(NUM_DIGITS + 1);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int BW = 4 * NUM_DIGITS;
    localparam logic [CW-1:0] COUNT_MAX = CW'(NUM_DIGITS);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    if (NUM_DIGITS < 2 || NUM_DIGITS > 8 || SCAN_DIV < 2 || BLINK_DIV < 1) begin : g_bad_param
        $error("ssd_entry_ctrl: parameter out of range");
    end

    // Digit i occupies buf_q[4*i +: 4]. Digits above count are always zero.
    logic [BW-1:0]   buf_q;
    logic [SW-1:0]   scan_cnt;
    logic [IW-1:0]   scan_idx;
    logic [3:0]      cur_digit;
    logic [6:0]      cur_seg;
    logic [NUM_DIGITS-1:0] cur_sel;
    logic            digit_entered;
    logic            blank_all;

    assign full = (count == COUNT_MAX);

    // Entry buffer, count and key_drop pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q    <= '0;
            count    <= '0;
            key_drop <= 1'b0;
        end else begin
            key_drop <= 1'b0;
            if (clear) begin
                buf_q <= '0;
                count <= '0;
            end else if (backspace) begin
                // The key strobe in the same cycle is discarded even when
                // there is nothing to remove.
                if (count != '0) begin
                    buf_q <= {4'h0, buf_q[BW-1:4]};
                    count <= count - 1'b1;
                end
            end else if (key_valid) begin
                if (full && (LOCK_WHEN_FULL != 0)) begin
                    key_drop <= 1'b1;
                end else begin
                    // When the buffer is full in shift mode, the oldest digit
                    // falls off the top.
                    buf_q <= {buf_q[BW-5:0], key_code};
                    if (!full) begin
                        count <= count + 1'b1;
                    end
                end
            end
        end
    end

    // Free-running scan. Entry activity never disturbs it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

`ifdef FULL_BLINK_EN
    localparam int BLW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLW-1:0] BLINK_LAST = BLW'(BLINK_DIV - 1);

    logic [BLW-1:0] blink_cnt;
    logic           blink_on;

    // The counter is held at its start point while the buffer is not full.
    // Each full period therefore starts with a whole "on" half-period, and
    // leaving full always returns the display to solid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (!full) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign blank_all = full && !blink_on;
`else
    assign blank_all = 1'b0;
`endif

    assign cur_digit     = buf_q[{scan_idx, 2'b00} +: 4];
    assign digit_entered = (CW'(scan_idx) < count);

    always_comb begin
        cur_sel           = '0;
        cur_sel[scan_idx] = 1'b1;
    end

    always_comb begin
        case (cur_digit)
            4'h0:    cur_seg = 7'b0111111;
            4'h1:    cur_seg = 7'b0000110;
            4'h2:    cur_seg = 7'b1011011;
            4'h3:    cur_seg = 7'b1001111;
            4'h4:    cur_seg = 7'b1100110;
            4'h5:    cur_seg = 7'b1101101;
            4'h6:    cur_seg = 7'b1111101;
            4'h7:    cur_seg = 7'b0000111;
            4'h8:    cur_seg = 7'b1111111;
            4'h9:    cur_seg = 7'b1101111;
            4'hA:    cur_seg = 7'b1110111;
            4'hB:    cur_seg = 7'b1111100;
            4'hC:    cur_seg = 7'b0111001;
            4'hD:    cur_seg = 7'b1011110;
            4'hE:    cur_seg = 7'b1111001;
            default: cur_seg = 7'b1110001;
        endcase
    end

    // seg and digit_sel are registered from the same scan index. They are
    // always aligned and lag the index by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg       <= 7'b0000000;
            digit_sel <= NUM_DIGITS'(1);
        end else begin
            digit_sel <= cur_sel;
            seg       <= (digit_entered && !blank_all) ? cur_seg : 7'b0000000;
        end
    end

endmodule
